// File: rtl/fifo_to_spi_master_if.sv
// Handshake and pin bundle between the FIFO-to-SPI drainer, its FIFO and the sensor SPI pins.
// Latency: none, wires only.
// Backpressure: the FIFO side is pull-only (empty flag gates reads); the SPI side has none.
interface fifo_to_spi_master_if;
   logic       start;
   logic [7:0] n_bytes;
   logic       busy;
   logic       done;
   logic       error;
   logic       fifo_rd_en;
   logic [7:0] fifo_dout;
   logic       fifo_valid;
   logic       fifo_empty;
   logic       spi_cs_n;
   logic       spi_sclk;
   logic       spi_mosi;

   // The SPI master itself
   modport master (
      input  start, n_bytes, fifo_dout, fifo_valid, fifo_empty,
      output busy, done, error, fifo_rd_en, spi_cs_n, spi_sclk, spi_mosi
   );

   // Controller, FIFO and sensor as seen from outside the master
   modport slave (
      output start, n_bytes, fifo_dout, fifo_valid, fifo_empty,
      input  busy, done, error, fifo_rd_en, spi_cs_n, spi_sclk, spi_mosi
   );
endinterface

// File: rtl/fifo_to_spi_master.sv
// Drains n_bytes from an 8-bit FIFO and sends them as one SPI mode-0 (MSB first) write under a single CS.
// Latency: 2 clk per byte fetch, 16*CLK_DIV clk per byte on the wire, CLK_DIV clk CS hold before done.
// Backpressure: stalls with SCLK low while the FIFO is empty; aborts with error after STALL_LIMIT clk.
module fifo_to_spi_master #(
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned STALL_LIMIT = 255
) (
   input  logic                  clk,
   input  logic                  reset_n,
   fifo_to_spi_master_if.master  bus
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_DATA,
      SHIFT,
      FINISH
   } state_t;

   localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
   localparam logic [15:0] STALL_LAST = 16'(STALL_LIMIT - 1);
   localparam logic [15:0] STALL_MAX  = 16'(STALL_LIMIT);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;      // bytes still to send
   logic [15:0] stall_q, stall_d;  // consecutive empty cycles in FETCH
   logic [7:0]  div_q, div_d;      // position inside the current SCLK half-period
   logic [2:0]  bit_q, bit_d;      // bit index inside the current byte
   logic [7:0]  sh_q, sh_d;        // byte being shifted, next bit out at [6]
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        cs_n_q, cs_n_d;
   logic        sclk_q, sclk_d;
   logic        mosi_q, mosi_d;
   logic        rd_en;
   logic        div_end;

   assign div_end = (div_q == DIV_LAST);

   // State and datapath registers; reset drops CS and parks the bus at once
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         stall_q <= 16'd0;
         div_q   <= 8'd0;
         bit_q   <= 3'd0;
         sh_q    <= 8'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cs_n_q  <= cs_n_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
      end
   end

   // Next-state, SPI sequencing and FIFO read strobe
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall_d = stall_q;
      div_d   = div_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      cs_n_d  = cs_n_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      rd_en   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.n_bytes == 8'd0) begin
                  // Empty burst: acknowledge without touching the bus
                  done_d = 1'b1;
               end else begin
                  cnt_d   = bus.n_bytes;
                  stall_d = 16'd0;
                  busy_d  = 1'b1;
                  cs_n_d  = 1'b0;
                  state_d = FETCH;
               end
            end
         end

         FETCH: begin
            if (!bus.fifo_empty) begin
               // Read only when data is there, so the FIFO can never underflow
               rd_en   = 1'b1;
               stall_d = 16'd0;
               state_d = WAIT_DATA;
            end else if (stall_q >= STALL_LAST) begin
               stall_d = STALL_MAX;
               cs_n_d  = 1'b1;
               err_d   = 1'b1;
               busy_d  = 1'b0;
               mosi_d  = 1'b0;
               state_d = IDLE;
            end else begin
               stall_d = stall_q + 16'd1;
            end
         end

         WAIT_DATA: begin
            if (bus.fifo_valid) begin
               sh_d    = bus.fifo_dout;
               mosi_d  = bus.fifo_dout[7];
               div_d   = 8'd0;
               bit_d   = 3'd0;
               sclk_d  = 1'b0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (!div_end) begin
               div_d = div_q + 8'd1;
            end else begin
               div_d = 8'd0;
               if (!sclk_q) begin
                  // Rising edge mid-bit: slave samples the stable MOSI
                  sclk_d = 1'b1;
               end else begin
                  // Falling edge: present the next bit
                  sclk_d = 1'b0;
                  sh_d   = {sh_q[6:0], 1'b0};
                  mosi_d = sh_q[6];
                  bit_d  = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                     end
                     state_d = (cnt_q <= 8'd1) ? FINISH : FETCH;
                  end
               end
            end
         end

         FINISH: begin
            // CS hold after the last falling SCLK edge
            if (!div_end) begin
               div_d = div_q + 8'd1;
            end else begin
               div_d   = 8'd0;
               cs_n_d  = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               mosi_d  = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.error      = err_q;
   assign bus.fifo_rd_en = rd_en;
   assign bus.spi_cs_n   = cs_n_q;
   assign bus.spi_sclk   = sclk_q;
   assign bus.spi_mosi   = mosi_q;

endmodule
